// File: rtl/conv_seq_pkg.sv
// Shared types and helpers for the convolution sequencer slice.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  // Number of dot products produced from one frame.
  function automatic int num_y(input int lenx, input int lenf);
    return lenx - lenf + 1;
  endfunction

  // Bits needed for a counter that walks 0 .. n-1 (never less than one).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_seq_lat_pipe.sv
// Delay line aligning {issue, first} with operands arriving at the accumulator.
module conv_seq_lat_pipe
#(
  parameter int unsigned DEPTH = 1
)
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_issue,
  input  logic i_first,
  output logic o_issue,
  output logic o_first
);

  logic [1:0] r_sr [DEPTH];

  // Shift {issue, first} one stage per cycle; reset empties the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_sr[i] <= '0;
      end
    end else begin
      r_sr[0] <= {i_issue, i_first};
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_issue = r_sr[DEPTH-1][1];
  assign o_first = r_sr[DEPTH-1][0];

endmodule

// File: rtl/conv_sequencer.sv
// Control FSM for the streaming 1-D convolution datapath.
// Loads LENX samples into x memory, then sequences LENX-LENF+1 dot products.
// Optional performance counters are built when CONV_SEQ_PERF_EN is defined.
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int LENX    = 8,
  parameter int LENF    = 4,
  parameter int ADDRX   = 3,
  parameter int ADDRF   = 2,
  parameter int MAC_LAT = 1
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  output logic             x_wr_en,
  output logic [ADDRX-1:0] x_addr,
  output logic [ADDRF-1:0] f_addr,
  output logic             acc_en,
  output logic             acc_clr,
  output logic             m_valid_y,
  input  logic             m_ready_y,
  output logic             busy
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      y_cnt
`endif
);

  localparam int NUM_Y = num_y(LENX, LENF);
  localparam int DW    = cnt_width(MAC_LAT);

  localparam logic [ADDRX-1:0] LAST_WR    = ADDRX'(LENX - 1);
  localparam logic [ADDRX-1:0] LAST_BASE  = ADDRX'(NUM_Y - 1);
  localparam logic [ADDRF-1:0] LAST_TAP   = ADDRF'(LENF - 1);
  localparam logic [DW-1:0]    LAST_DRAIN = DW'(MAC_LAT - 1);

  state_t           r_state;
  logic [ADDRX-1:0] r_wr_cnt;
  logic [ADDRX-1:0] r_base;
  logic [ADDRF-1:0] r_tap;
  logic [DW-1:0]    r_drain;

  logic w_ld_hs;
  logic w_y_hs;
  logic w_issue;
  logic w_first;
  logic w_d_issue;
  logic w_d_first;

  // s_ready_x is gated by reset so every output reads 0 while reset is held.
  assign s_ready_x = (r_state == LOAD) & reset;
  assign x_wr_en   = s_valid_x & s_ready_x;
  assign w_ld_hs   = x_wr_en;
  assign m_valid_y = (r_state == OUTPUT);
  assign w_y_hs    = m_valid_y & m_ready_y;
  assign busy      = (r_state != LOAD);

  // r_tap stays at its last value after COMPUTE, so addresses hold through DRAIN/OUTPUT.
  assign x_addr  = (r_state == LOAD) ? r_wr_cnt : (r_base + ADDRX'(r_tap));
  assign f_addr  = r_tap;
  assign w_issue = (r_state == COMPUTE);
  assign w_first = (r_tap == '0);

  conv_seq_lat_pipe #(
    .DEPTH (MAC_LAT)
  ) u_lat_pipe (
    .clk     (clk),
    .rst_n   (reset),
    .i_issue (w_issue),
    .i_first (w_first),
    .o_issue (w_d_issue),
    .o_first (w_d_first)
  );

  assign acc_en  = w_d_issue;
  assign acc_clr = w_d_issue & w_d_first;

  // Frame sequencing: load, per-output compute/drain, then output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= LOAD;
      r_wr_cnt <= '0;
      r_base   <= '0;
      r_tap    <= '0;
      r_drain  <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_ld_hs) begin
            if (r_wr_cnt == LAST_WR) begin
              r_state  <= COMPUTE;
              r_wr_cnt <= '0;
              r_tap    <= '0;
            end else begin
              r_wr_cnt <= r_wr_cnt + ADDRX'(1);
            end
          end
        end
        COMPUTE: begin
          if (r_tap == LAST_TAP) begin
            r_state <= DRAIN;
            r_drain <= '0;
          end else begin
            r_tap <= r_tap + ADDRF'(1);
          end
        end
        DRAIN: begin
          if (r_drain == LAST_DRAIN) begin
            r_state <= OUTPUT;
          end else begin
            r_drain <= r_drain + DW'(1);
          end
        end
        OUTPUT: begin
          if (w_y_hs) begin
            if (r_base == LAST_BASE) begin
              r_base  <= '0;
              r_state <= LOAD;
            end else begin
              r_base  <= r_base + ADDRX'(1);
              r_tap   <= '0;
              r_state <= COMPUTE;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_y_cnt;

  // Saturating stall and output counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_y_cnt     <= '0;
    end else begin
      if (m_valid_y && !m_ready_y && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_y_hs && (r_y_cnt != '1)) begin
        r_y_cnt <= r_y_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign y_cnt     = r_y_cnt;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: LENX=8/LENF=4/MAC_LAT=1 and LENX=LENF=4/MAC_LAT=2.
module tb_conv_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_sv = 1'b0, a_mr = 1'b0;
  logic       a_srdy, a_wr, a_acc, a_clr, a_mv, a_busy;
  logic [2:0] a_xaddr;
  logic [1:0] a_faddr;

  logic       b_sv = 1'b0, b_mr = 1'b0;
  logic       b_srdy, b_wr, b_acc, b_clr, b_mv, b_busy;
  logic [1:0] b_xaddr;
  logic [1:0] b_faddr;

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] a_stall, a_ycnt, b_stall, b_ycnt;
`endif

  conv_sequencer #(.LENX(8), .LENF(4), .ADDRX(3), .ADDRF(2), .MAC_LAT(1)) u_dut_a (
    .clk(clk), .reset(rst_n), .s_valid_x(a_sv), .s_ready_x(a_srdy), .x_wr_en(a_wr),
    .x_addr(a_xaddr), .f_addr(a_faddr), .acc_en(a_acc), .acc_clr(a_clr),
    .m_valid_y(a_mv), .m_ready_y(a_mr), .busy(a_busy)
`ifdef CONV_SEQ_PERF_EN
    , .stall_cnt(a_stall), .y_cnt(a_ycnt)
`endif
  );

  conv_sequencer #(.LENX(4), .LENF(4), .ADDRX(2), .ADDRF(2), .MAC_LAT(2)) u_dut_b (
    .clk(clk), .reset(rst_n), .s_valid_x(b_sv), .s_ready_x(b_srdy), .x_wr_en(b_wr),
    .x_addr(b_xaddr), .f_addr(b_faddr), .acc_en(b_acc), .acc_clr(b_clr),
    .m_valid_y(b_mv), .m_ready_y(b_mr), .busy(b_busy)
`ifdef CONV_SEQ_PERF_EN
    , .stall_cnt(b_stall), .y_cnt(b_ycnt)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Observations gathered by run_frame for DUT A.
  int n_wr, wr_bad, early_busy, inv_bad, stall_bad, stall_seen, ny, timeout, aborted;
  int entry_busy, entry_rdy, rdy_after_last, busy_after_last;
  int wr_addr [16];
  int valid_t [8];
  int hs_t [8];
  int first_acc_t [8];
  int acc_n [8];
  int clr_bad [8];
  int opx [8][8];
  int opf [8][8];
  logic [10:0] rst_vec;

  // Drive one frame into DUT A and record what it does. Inputs change at
  // posedge+1, outputs are sampled at negedge.
  task automatic run_frame(input bit gaps, input int hold_y, input int hold_n, input int rst_y);
    int k, acc_cnt, t, yi, prev_x, prev_f, held_x, held_f;
    n_wr = 0; wr_bad = 0; early_busy = 0; inv_bad = 0; stall_bad = 0; stall_seen = 0;
    timeout = 0; aborted = 0; entry_busy = -1; entry_rdy = -1;
    rdy_after_last = -1; busy_after_last = -1; rst_vec = '1;
    for (int i = 0; i < 8; i++) begin
      valid_t[i] = -1; hs_t[i] = -1; first_acc_t[i] = -1; acc_n[i] = 0; clr_bad[i] = 0;
      for (int j = 0; j < 8; j++) begin opx[i][j] = -1; opf[i][j] = -1; end
    end
    k = 0; acc_cnt = 0; prev_x = 0; prev_f = 0; held_x = 0; held_f = 0;
    a_mr = 1'b1;
    while (acc_cnt < 8 && k < 200) begin
      a_sv = gaps ? ((k % 3) == 0) : 1'b1;
      @(negedge clk);
      if (a_wr !== (a_sv & a_srdy)) wr_bad++;
      if (a_busy) early_busy++;
      if (a_wr && n_wr < 16) begin wr_addr[n_wr] = int'(a_xaddr); n_wr++; end
      if (a_sv && a_srdy) acc_cnt++;
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) timeout++;
    a_sv = 1'b1;
    t = 0; yi = 0;
    while (yi < 5 && t < 300) begin
      a_mr = !(yi == hold_y && stall_seen < hold_n);
      @(negedge clk);
      if (t == 0) begin entry_busy = int'(a_busy); entry_rdy = int'(a_srdy); end
      if (a_srdy && a_mv) inv_bad++;
      if (a_wr) inv_bad++;
      if (a_acc && (!a_busy || a_mv)) inv_bad++;
      if (a_acc) begin
        if (acc_n[yi] == 0) first_acc_t[yi] = t;
        if (acc_n[yi] < 8) begin opx[yi][acc_n[yi]] = prev_x; opf[yi][acc_n[yi]] = prev_f; end
        if (a_clr !== (acc_n[yi] == 0)) clr_bad[yi]++;
        acc_n[yi]++;
      end else if (a_clr) begin
        clr_bad[yi]++;
      end
      if (a_mv) begin
        if (valid_t[yi] < 0) begin valid_t[yi] = t; held_x = int'(a_xaddr); held_f = int'(a_faddr); end
        if (int'(a_xaddr) != held_x || int'(a_faddr) != held_f) stall_bad++;
        if (a_mr) begin hs_t[yi] = t; yi++; end
        else stall_seen++;
      end
      prev_x = int'(a_xaddr); prev_f = int'(a_faddr);
      if (yi == rst_y && acc_n[yi] == 1 && !a_mv) begin
        rst_n = 1'b0;
        #1;
        rst_vec = {a_srdy, a_wr, a_xaddr, a_faddr, a_acc, a_clr, a_mv, a_busy};
        a_sv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
      t++;
    end
    ny = yi;
    a_sv = 1'b0;
    if (aborted == 0) begin
      if (t >= 300) timeout++;
      @(negedge clk);
      rdy_after_last = int'(a_srdy);
      busy_after_last = int'(a_busy);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [10:0] va, vb;
    rst_n = 1'b0; a_sv = 1'b1; a_mr = 1'b1; b_sv = 1'b1; b_mr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    va = {a_srdy, a_wr, a_xaddr, a_faddr, a_acc, a_clr, a_mv, a_busy};
    vb = {b_srdy, b_wr, b_xaddr, b_faddr, b_acc, b_clr, b_mv, b_busy};
    tests_run++;
    if (va !== '0) begin tests_failed++; $display("FAIL reset_outs_a: got %b expected all zero", va); end
    tests_run++;
    if (vb !== '0) begin tests_failed++; $display("FAIL reset_outs_b: got %b expected all zero", vb); end
`ifdef CONV_SEQ_PERF_EN
    tests_run++;
    if (a_stall !== 32'd0 || a_ycnt !== 32'd0) begin
      tests_failed++; $display("FAIL reset_perf: got stall=%0d y=%0d expected 0 0", a_stall, a_ycnt);
    end
`endif
    a_sv = 1'b0; b_sv = 1'b0; b_mr = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (a_srdy !== 1'b1 || a_busy !== 1'b0) begin
      tests_failed++; $display("FAIL post_reset_load: got ready=%b busy=%b expected 1 0", a_srdy, a_busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream_basic();
    run_frame(1'b0, -1, 0, -1);
    tests_run++;
    if (timeout !== 0) begin tests_failed++; $display("FAIL basic_timeout: got %0d expected 0", timeout); end
    tests_run++;
    if (n_wr !== 8) begin tests_failed++; $display("FAIL basic_n_wr: got %0d expected 8", n_wr); end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (wr_addr[i] !== i) begin tests_failed++; $display("FAIL basic_wr_addr[%0d]: got %0d expected %0d", i, wr_addr[i], i); end
    end
    tests_run++;
    if (wr_bad !== 0 || early_busy !== 0) begin
      tests_failed++; $display("FAIL basic_load_strobe: got wr_bad=%0d early_busy=%0d expected 0 0", wr_bad, early_busy);
    end
    tests_run++;
    if (entry_busy !== 1 || entry_rdy !== 0) begin
      tests_failed++; $display("FAIL basic_entry: got busy=%0d ready=%0d expected 1 0", entry_busy, entry_rdy);
    end
    tests_run++;
    if (valid_t[0] !== 5) begin tests_failed++; $display("FAIL basic_first_valid: got %0d expected 5", valid_t[0]); end
    tests_run++;
    if (ny !== 5) begin tests_failed++; $display("FAIL basic_num_y: got %0d expected 5", ny); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (hs_t[i+1] - hs_t[i] !== 6) begin
        tests_failed++; $display("FAIL basic_hs_gap[%0d]: got %0d expected 6", i, hs_t[i+1] - hs_t[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (acc_n[i] !== 4 || clr_bad[i] !== 0) begin
        tests_failed++; $display("FAIL basic_acc[%0d]: got en=%0d clr_bad=%0d expected 4 0", i, acc_n[i], clr_bad[i]);
      end
      for (int j = 0; j < 4; j++) begin
        tests_run++;
        if (opx[i][j] !== i + j || opf[i][j] !== j) begin
          tests_failed++;
          $display("FAIL basic_operand[%0d][%0d]: got x=%0d f=%0d expected x=%0d f=%0d", i, j, opx[i][j], opf[i][j], i + j, j);
        end
      end
    end
    tests_run++;
    if (inv_bad !== 0) begin tests_failed++; $display("FAIL basic_invariants: got %0d violations expected 0", inv_bad); end
    tests_run++;
    if (rdy_after_last !== 1 || busy_after_last !== 0) begin
      tests_failed++; $display("FAIL basic_back_to_load: got ready=%0d busy=%0d expected 1 0", rdy_after_last, busy_after_last);
    end
  endtask

  task automatic test_stall();
    run_frame(1'b0, 1, 3, -1);
    tests_run++;
    if (timeout !== 0 || ny !== 5) begin
      tests_failed++; $display("FAIL stall_frame: got timeout=%0d ny=%0d expected 0 5", timeout, ny);
    end
    tests_run++;
    if (stall_seen !== 3 || hs_t[1] - valid_t[1] !== 3) begin
      tests_failed++; $display("FAIL stall_hold: got stalls=%0d hold=%0d expected 3 3", stall_seen, hs_t[1] - valid_t[1]);
    end
    tests_run++;
    if (stall_bad !== 0 || inv_bad !== 0) begin
      tests_failed++; $display("FAIL stall_stable: got addr_moves=%0d inv=%0d expected 0 0", stall_bad, inv_bad);
    end
    tests_run++;
    if (first_acc_t[2] - hs_t[1] !== 2 || valid_t[2] - hs_t[1] !== 6) begin
      tests_failed++;
      $display("FAIL stall_resume: got acc_dly=%0d valid_dly=%0d expected 2 6", first_acc_t[2] - hs_t[1], valid_t[2] - hs_t[1]);
    end
    tests_run++;
    if (acc_n[1] !== 4 || acc_n[2] !== 4 || opx[2][0] !== 2) begin
      tests_failed++; $display("FAIL stall_acc: got en1=%0d en2=%0d x20=%0d expected 4 4 2", acc_n[1], acc_n[2], opx[2][0]);
    end
`ifdef CONV_SEQ_PERF_EN
    tests_run++;
    if (a_stall !== 32'd3 || a_ycnt !== 32'd10) begin
      tests_failed++; $display("FAIL stall_perf: got stall=%0d y=%0d expected 3 10", a_stall, a_ycnt);
    end
`endif
  endtask

  task automatic test_gaps();
    run_frame(1'b1, -1, 0, -1);
    tests_run++;
    if (timeout !== 0 || n_wr !== 8 || wr_bad !== 0) begin
      tests_failed++; $display("FAIL gaps_load: got timeout=%0d n_wr=%0d wr_bad=%0d expected 0 8 0", timeout, n_wr, wr_bad);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (wr_addr[i] !== i) begin tests_failed++; $display("FAIL gaps_wr_addr[%0d]: got %0d expected %0d", i, wr_addr[i], i); end
    end
    tests_run++;
    if (early_busy !== 0 || entry_busy !== 1) begin
      tests_failed++; $display("FAIL gaps_compute_entry: got early=%0d entry=%0d expected 0 1", early_busy, entry_busy);
    end
    tests_run++;
    if (valid_t[0] !== 5 || ny !== 5 || opx[4][3] !== 7) begin
      tests_failed++; $display("FAIL gaps_outputs: got t=%0d ny=%0d x43=%0d expected 5 5 7", valid_t[0], ny, opx[4][3]);
    end
  endtask

  task automatic test_reset_mid();
    int mv_seen, busy_seen, rdy_seen;
    run_frame(1'b0, -1, 0, 2);
    tests_run++;
    if (aborted !== 1) begin tests_failed++; $display("FAIL rstmid_reached: got %0d expected 1", aborted); end
    tests_run++;
    if (rst_vec !== '0) begin tests_failed++; $display("FAIL rstmid_outs: got %b expected all zero", rst_vec); end
    tests_run++;
    if (valid_t[2] !== -1) begin tests_failed++; $display("FAIL rstmid_no_y3: got %0d expected -1", valid_t[2]); end
    mv_seen = 0; busy_seen = 0; rdy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_mv) mv_seen++;
      if (a_busy) busy_seen++;
      if (a_srdy) rdy_seen++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (mv_seen !== 0 || busy_seen !== 0 || rdy_seen !== 10) begin
      tests_failed++; $display("FAIL rstmid_idle: got mv=%0d busy=%0d rdy=%0d expected 0 0 10", mv_seen, busy_seen, rdy_seen);
    end
`ifdef CONV_SEQ_PERF_EN
    tests_run++;
    if (a_stall !== 32'd0 || a_ycnt !== 32'd0) begin
      tests_failed++; $display("FAIL rstmid_perf: got stall=%0d y=%0d expected 0 0", a_stall, a_ycnt);
    end
`endif
    run_frame(1'b0, -1, 0, -1);
    tests_run++;
    if (timeout !== 0 || n_wr !== 8 || wr_addr[0] !== 0 || wr_addr[7] !== 7) begin
      tests_failed++; $display("FAIL rstmid_reload: got timeout=%0d n_wr=%0d a0=%0d a7=%0d expected 0 8 0 7", timeout, n_wr, wr_addr[0], wr_addr[7]);
    end
    tests_run++;
    if (valid_t[0] !== 5 || ny !== 5 || inv_bad !== 0) begin
      tests_failed++; $display("FAIL rstmid_fresh: got t=%0d ny=%0d inv=%0d expected 5 5 0", valid_t[0], ny, inv_bad);
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (acc_n[i] !== 4 || clr_bad[i] !== 0 || opx[i][0] !== i) begin
        tests_failed++; $display("FAIL rstmid_y[%0d]: got en=%0d clr_bad=%0d x0=%0d expected 4 0 %0d", i, acc_n[i], clr_bad[i], opx[i][0], i);
      end
    end
  endtask

  task automatic test_lenf_eq_lenx();
    int n, k, bw, t, vt, ht, accs, clrb, entry, extra_mv, rdy_after, busy_after;
    n = 0; k = 0; bw = 0; vt = -1; ht = -1; accs = 0; clrb = 0; entry = -1; extra_mv = 0;
    b_sv = 1'b1; b_mr = 1'b1;
    while (n < 4 && k < 50) begin
      @(negedge clk);
      if (b_sv && b_srdy) n++;
      if (b_wr) bw++;
      @(posedge clk); #1;
      k++;
    end
    b_sv = 1'b0;
    t = 0;
    while (ht < 0 && t < 50) begin
      @(negedge clk);
      if (t == 0) entry = int'(b_busy);
      if (b_acc) begin
        if (b_clr !== (accs == 0)) clrb++;
        accs++;
      end else if (b_clr) begin
        clrb++;
      end
      if (b_mv && vt < 0) vt = t;
      if (b_mv && b_mr) ht = t;
      @(posedge clk); #1;
      t++;
    end
    @(negedge clk);
    rdy_after = int'(b_srdy); busy_after = int'(b_busy);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b_mv) extra_mv++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (bw !== 4 || entry !== 1) begin tests_failed++; $display("FAIL eq_load: got writes=%0d entry=%0d expected 4 1", bw, entry); end
    tests_run++;
    if (vt !== 6) begin tests_failed++; $display("FAIL eq_first_valid: got %0d expected 6", vt); end
    tests_run++;
    if (accs !== 4 || clrb !== 0) begin tests_failed++; $display("FAIL eq_acc: got en=%0d clr_bad=%0d expected 4 0", accs, clrb); end
    tests_run++;
    if (rdy_after !== 1 || busy_after !== 0 || extra_mv !== 0) begin
      tests_failed++; $display("FAIL eq_one_y: got ready=%0d busy=%0d extra=%0d expected 1 0 0", rdy_after, busy_after, extra_mv);
    end
  endtask

  initial begin
    test_reset();
    test_stream_basic();
    test_stall();
    test_gaps();
    test_reset_mid();
    test_lenf_eq_lenx();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Control FSM for the streaming 1-D convolution datapath: x sample memory, f coefficient ROM, and a saturating MAC accumulator with an output register.
- Accepts LENX input samples over a valid/ready slave port and writes them to x memory.
- Then sequences LENX-LENF+1 dot products: drives x/f read addresses and the accumulator clear/enable strobes, and presents each result over a valid/ready master handshake.
- Sits between the top-level stream ports and the memory/accumulator instances; carries no data path itself.

Parameters:
- LENX, 8, input vector length (samples per frame).
- LENF, 4, filter length; must satisfy 1 <= LENF <= LENX.
- ADDRX, 3, x address width, >= $clog2(LENX).
- ADDRF, 2, f address width, >= $clog2(LENF).
- MAC_LAT, 1, cycles from address issue to operand valid at the accumulator input; must be >= 1.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- s_valid_x, input, 1, input sample valid.
- s_ready_x, output, 1, controller accepts a sample this cycle.
- x_wr_en, output, 1, x memory write strobe.
- x_addr, output, ADDRX, x memory address (write in LOAD, read in COMPUTE).
- f_addr, output, ADDRF, coefficient ROM address.
- acc_en, output, 1, accumulator accepts an operand pair this cycle.
- acc_clr, output, 1, with acc_en: load the product instead of adding it.
- m_valid_y, output, 1, accumulator output register holds a final y.
- m_ready_y, input, 1, downstream accepts y.
- busy, output, 1, high in any state other than LOAD.

Behaviour:
- Reset (reset low, async): state=LOAD; wr_cnt=0; base=0; tap=0; latency pipe cleared. All outputs 0, including s_ready_x.
- LOAD:
  - s_ready_x=1.
  - x_wr_en = s_valid_x & s_ready_x (combinational); x_addr=wr_cnt.
  - On each handshake wr_cnt++.
  - Handshake with wr_cnt==LENX-1: next state COMPUTE, wr_cnt=0, tap=0.
  - Gaps in s_valid_x stall without side effects.
- COMPUTE, exactly LENF cycles:
  - s_ready_x=0; x_addr=base+tap; f_addr=tap; issue=1.
  - tap++ each cycle; at tap==LENF-1, next state DRAIN.
- Latency pipe:
  - issue and first=(tap==0) delayed MAC_LAT cycles.
  - acc_en = delayed issue; acc_clr = delayed first & delayed issue.
- DRAIN: MAC_LAT cycles, no new issues; the last acc_en fires in the final DRAIN cycle.
- OUTPUT:
  - m_valid_y=1 the cycle after the last acc_en, held until m_ready_y.
  - acc_en=0 throughout; x_addr/f_addr hold their last values.
  - On handshake:
    - if base==LENX-LENF: base=0, next state LOAD (s_ready_x=1 the following cycle);
    - else: base++, tap=0, next state COMPUTE.
- Latency:
  - First m_valid_y rises LENF+MAC_LAT cycles after COMPUTE entry.
  - Each subsequent y, with m_ready_y=1, takes LENF+MAC_LAT+1 cycles handshake-to-handshake.
- Invariants:
  - s_ready_x and m_valid_y are never both 1.
  - x_wr_en is 0 outside LOAD.
  - acc_en is never high in LOAD or OUTPUT.
- m_ready_y high outside OUTPUT is ignored. s_valid_x outside LOAD is ignored; the sample is not consumed.
- Reset asserted mid-frame aborts immediately: partial frame discarded, no m_valid_y, LOAD resumes with wr_cnt=0.
- LENF==LENX: one y per frame.

Optional Feature:
- Macro: CONV_SEQ_PERF_EN.
- Defined:
  - Adds output ports stall_cnt [31:0] and y_cnt [31:0].
  - stall_cnt increments each cycle with m_valid_y=1 and m_ready_y=0.
  - y_cnt increments on each y handshake.
  - Both saturate at 2^32-1 and are cleared only by reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package conv_seq_pkg:
  - state_t enum {LOAD, COMPUTE, DRAIN, OUTPUT};
  - function num_y(LENX,LENF) = LENX-LENF+1;
  - localparam-style width helpers.
- Sub-module conv_seq_lat_pipe:
  - MAC_LAT-deep shift register carrying {issue, first};
  - asynchronous active-low reset to zero;
  - instantiated once.

Test Plan:
- LENX=8, LENF=4, MAC_LAT=1, samples 1..8 with continuous valid:
  - exactly 8 x_wr_en pulses at addresses 0..7, then s_ready_x=0;
  - first m_valid_y 5 cycles after COMPUTE entry;
  - 5 y handshakes, read bases 0..4 (x_addr sequences 0-3, 1-4 ... 4-7);
  - s_ready_x=1 the cycle after the 5th handshake.
- Per dot product: acc_clr high only on the first acc_en of each group; exactly 4 acc_en per y.
- Hold m_ready_y=0 for 3 cycles on y #2:
  - m_valid_y stays 1, acc_en=0, addresses stable;
  - next COMPUTE starts the cycle after the handshake;
  - with CONV_SEQ_PERF_EN, stall_cnt=3.
- s_valid_x toggling 1,0,0,1,...: only handshake cycles write, addresses contiguous, COMPUTE entered only after the 8th accepted sample.
- Assert reset for 1 cycle during COMPUTE of y #3:
  - all outputs 0 asynchronously, no m_valid_y for the aborted frame;
  - a fresh 8-sample frame produces 5 correct y.
- LENF=LENX=4, MAC_LAT=2: one y per frame, first m_valid_y 6 cycles after COMPUTE entry, then LOAD.
